// File: rtl/aes_pkg.sv
// AES-128 constants shared by the key-schedule block: round count, Rcon table,
// 32-bit word type and the forward S-box.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] word_t;

  // Index 0 is unused; stage r reads RCON[r].
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5, 8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76,
    8'hCA, 8'h82, 8'hC9, 8'h7D, 8'hFA, 8'h59, 8'h47, 8'hF0, 8'hAD, 8'hD4, 8'hA2, 8'hAF, 8'h9C, 8'hA4, 8'h72, 8'hC0,
    8'hB7, 8'hFD, 8'h93, 8'h26, 8'h36, 8'h3F, 8'hF7, 8'hCC, 8'h34, 8'hA5, 8'hE5, 8'hF1, 8'h71, 8'hD8, 8'h31, 8'h15,
    8'h04, 8'hC7, 8'h23, 8'hC3, 8'h18, 8'h96, 8'h05, 8'h9A, 8'h07, 8'h12, 8'h80, 8'hE2, 8'hEB, 8'h27, 8'hB2, 8'h75,
    8'h09, 8'h83, 8'h2C, 8'h1A, 8'h1B, 8'h6E, 8'h5A, 8'hA0, 8'h52, 8'h3B, 8'hD6, 8'hB3, 8'h29, 8'hE3, 8'h2F, 8'h84,
    8'h53, 8'hD1, 8'h00, 8'hED, 8'h20, 8'hFC, 8'hB1, 8'h5B, 8'h6A, 8'hCB, 8'hBE, 8'h39, 8'h4A, 8'h4C, 8'h58, 8'hCF,
    8'hD0, 8'hEF, 8'hAA, 8'hFB, 8'h43, 8'h4D, 8'h33, 8'h85, 8'h45, 8'hF9, 8'h02, 8'h7F, 8'h50, 8'h3C, 8'h9F, 8'hA8,
    8'h51, 8'hA3, 8'h40, 8'h8F, 8'h92, 8'h9D, 8'h38, 8'hF5, 8'hBC, 8'hB6, 8'hDA, 8'h21, 8'h10, 8'hFF, 8'hF3, 8'hD2,
    8'hCD, 8'h0C, 8'h13, 8'hEC, 8'h5F, 8'h97, 8'h44, 8'h17, 8'hC4, 8'hA7, 8'h7E, 8'h3D, 8'h64, 8'h5D, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4F, 8'hDC, 8'h22, 8'h2A, 8'h90, 8'h88, 8'h46, 8'hEE, 8'hB8, 8'h14, 8'hDE, 8'h5E, 8'h0B, 8'hDB,
    8'hE0, 8'h32, 8'h3A, 8'h0A, 8'h49, 8'h06, 8'h24, 8'h5C, 8'hC2, 8'hD3, 8'hAC, 8'h62, 8'h91, 8'h95, 8'hE4, 8'h79,
    8'hE7, 8'hC8, 8'h37, 8'h6D, 8'h8D, 8'hD5, 8'h4E, 8'hA9, 8'h6C, 8'h56, 8'hF4, 8'hEA, 8'h65, 8'h7A, 8'hAE, 8'h08,
    8'hBA, 8'h78, 8'h25, 8'h2E, 8'h1C, 8'hA6, 8'hB4, 8'hC6, 8'hE8, 8'hDD, 8'h74, 8'h1F, 8'h4B, 8'hBD, 8'h8B, 8'h8A,
    8'h70, 8'h3E, 8'hB5, 8'h66, 8'h48, 8'h03, 8'hF6, 8'h0E, 8'h61, 8'h35, 8'h57, 8'hB9, 8'h86, 8'hC1, 8'h1D, 8'h9E,
    8'hE1, 8'hF8, 8'h98, 8'h11, 8'h69, 8'hD9, 8'h8E, 8'h94, 8'h9B, 8'h1E, 8'h87, 8'hE9, 8'hCE, 8'h55, 8'h28, 8'hDF,
    8'h8C, 8'hA1, 8'h89, 8'h0D, 8'hBF, 8'hE6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2D, 8'h0F, 8'hB0, 8'h54, 8'hBB, 8'h16
  };

endpackage

// File: rtl/aes_round_key_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_round_key.sv
// AES-128 round-key generator: any round 0..10 computed directly from the cipher key.
// Define AES_RK_COMB_OUT_EN for a zero-latency combinational output instead of a registered one.
module aes_round_key
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   round,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         out_valid
);

  logic [127:0] key_s [0:AES_NR];
  logic [127:0] sel_s;

  assign key_s[0] = in;

  for (genvar r = 1; r <= AES_NR; r++) begin : g_stage
    word_t w0_s, w1_s, w2_s, w3_s;
    word_t rot_s, sub_s, t_s;
    word_t n0_s, n1_s, n2_s, n3_s;

    assign w0_s  = key_s[r-1][127:96];
    assign w1_s  = key_s[r-1][95:64];
    assign w2_s  = key_s[r-1][63:32];
    assign w3_s  = key_s[r-1][31:0];
    assign rot_s = {w3_s[23:0], w3_s[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (
        .in_byte  (rot_s[8*b +: 8]),
        .out_byte (sub_s[8*b +: 8])
      );
    end

    assign t_s  = sub_s ^ {RCON[r], 24'h000000};
    assign n0_s = w0_s ^ t_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;
    assign key_s[r] = {n0_s, n1_s, n2_s, n3_s};
  end

  // Round select; indices past the last round yield an all-zero key.
  always_comb begin
    sel_s = 128'h0;
    if (round <= 4'(AES_NR)) begin
      sel_s = key_s[round];
    end else begin
      sel_s = 128'h0;
    end
  end

`ifdef AES_RK_COMB_OUT_EN
  logic unused_s;

  assign unused_s  = clk ^ rst;
  assign out       = sel_s;
  assign out_valid = in_valid;
`else
  logic [127:0] out_d, out_q;
  logic         out_valid_d, out_valid_q;

  // Capture on accepted requests; data holds across idle cycles while valid drops.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = sel_s;
      out_valid_d = 1'b1;
    end else begin
      out_d       = out_q;
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_aes_round_key.sv
// Directed scoreboard bench for aes_round_key; the same suite covers both the
// registered build and the AES_RK_COMB_OUT_EN combinational build.
module tb_aes_round_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   round;
  logic [127:0] in;
  logic [127:0] out;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q [$];
  logic [127:0] held = 128'h0;

  localparam logic [127:0] KEY_A    = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] KEY_A_R1 = 128'hD6AA74FD_D2AF72FA_DAA678F1_D6AB76FE;
  localparam logic [127:0] KEY_A_RA = 128'h13111D7F_E3944A17_F307A78B_4D2B30C5;
  localparam logic [127:0] KEY_B    = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] KEY_B_R1 = 128'hA0FAFE17_88542CB1_23A33939_2A6C7605;
  localparam logic [127:0] KEY_B_R2 = 128'hF2C295F2_7A96B943_5935807A_7359F67F;
  localparam logic [127:0] KEY_B_R3 = 128'h3D80477D_4716FE3E_1E237E44_6D7A883B;
  localparam logic [127:0] KEY_B_RA = 128'hD014F9A8_C9EE2589_E13F0CC8_B6630CA6;

  aes_round_key dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .round     (round),
    .in        (in),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's request at a negedge; compare when the result is due.
  task automatic step(input string tag, input logic v, input logic [3:0] r,
                      input logic [127:0] k, input logic [127:0] e);
    logic [127:0] exp_out;
    in_valid = v;
    round    = r;
    in       = k;
    if (v) sb_q.push_back(e);
`ifdef AES_RK_COMB_OUT_EN
    #1;
`else
    @(negedge clk);
`endif
    if (v) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
        exp_out = sb_q.pop_front();
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_valid"}, {127'b0, out_valid}, 128'h1);
        held = exp_out;
      end
    end else begin
      chk({tag, "_valid"}, {127'b0, out_valid}, 128'h0);
`ifndef AES_RK_COMB_OUT_EN
      chk({tag, "_hold"}, out, held);
`endif
    end
`ifdef AES_RK_COMB_OUT_EN
    @(negedge clk);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    round    = 4'd0;
    in       = 128'h0;
    #2;
`ifndef AES_RK_COMB_OUT_EN
    chk("rst_out", out, 128'h0);
    chk("rst_valid", {127'b0, out_valid}, 128'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    step("a_r0",  1'b1, 4'd0,  KEY_A, KEY_A);
    step("a_r1",  1'b1, 4'd1,  KEY_A, KEY_A_R1);
    step("a_r10", 1'b1, 4'd10, KEY_A, KEY_A_RA);
    step("idle1", 1'b0, 4'd3,  KEY_B, 128'h0);
    step("b_r1",  1'b1, 4'd1,  KEY_B, KEY_B_R1);
    step("b_r10", 1'b1, 4'd10, KEY_B, KEY_B_RA);
    step("b_r0",  1'b1, 4'd0,  KEY_B, KEY_B);
    step("idle2", 1'b0, 4'd0,  KEY_A, 128'h0);
    step("bb_r1", 1'b1, 4'd1,  KEY_B, KEY_B_R1);
    step("bb_r2", 1'b1, 4'd2,  KEY_B, KEY_B_R2);
    step("bb_r3", 1'b1, 4'd3,  KEY_B, KEY_B_R3);
    step("r12",   1'b1, 4'd12, KEY_B, 128'h0);
    step("r11",   1'b1, 4'd11, KEY_A, 128'h0);
    step("r15",   1'b1, 4'd15, KEY_A, 128'h0);
    step("a_r1b", 1'b1, 4'd1,  KEY_A, KEY_A_R1);

`ifndef AES_RK_COMB_OUT_EN
    // Mid-run reset while a result is held: must clear without a clock edge.
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", out, 128'h0);
    chk("mid_rst_valid", {127'b0, out_valid}, 128'h0);
    @(negedge clk);
    rst  = 1'b0;
    held = 128'h0;
    step("post_rst1", 1'b0, 4'd1, KEY_A, 128'h0);
    step("post_rst2", 1'b0, 4'd1, KEY_A, 128'h0);

    // Request presented while reset is asserted is discarded.
    in_valid = 1'b1;
    round    = 4'd1;
    in       = KEY_B;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("drop_out", out, 128'h0);
    chk("drop_valid", {127'b0, out_valid}, 128'h0);
    @(negedge clk);
    step("after_drop", 1'b1, 4'd10, KEY_B, KEY_B_RA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
